// File: rtl/data_mem_ctrl.sv
// Pipelined RISC-V data memory with byte/half/word access, lane-masked stores and error flagging.
// Latency: response enters the FIFO READ_LATENCY edges after accept; rsp_valid follows one cycle later when the FIFO is empty.
// Backpressure: req_ready drops when in-flight plus queued responses reach FIFO_DEPTH, so no response is ever dropped.

module data_mem_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic             pop_vld_o,
    output logic [WIDTH-1:0] pop_dat_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;

    assign pop       = pop_rdy_i && pop_vld_o;
    assign pop_vld_o = (cnt_q != '0);
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Entry storage; contents are don't-care until the count covers them, so no reset.
    always_ff @(posedge clock) begin
        if (push_vld_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_vld_i) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_vld_i, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Upstream credit accounting must make a push into a full queue impossible.
    always_ff @(posedge clock) begin
        if (reset && push_vld_i) begin
            assert (cnt_q != CNT_W'(DEPTH));
        end
    end
endmodule

module data_mem_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 64,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);
    localparam int FIFO_DEPTH = READ_LATENCY + 1;
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int OUT_W      = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic [1:0]            off;
    logic                  req_err;
    logic                  acc;
    logic                  pop;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wlane;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  alive_q;
    logic [OUT_W-1:0]      out_q, out_d;

    // Final-stage view of the response being pushed.
    logic                  f_vld, f_err, f_we, f_uns;
    logic [1:0]            f_size, f_off;
    logic [DATA_WIDTH-1:0] f_word;
    logic [7:0]            f_byte;
    logic [15:0]           f_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  fifo_vld;
    logic [DATA_WIDTH:0]   fifo_dat;

    assign word_idx = req_addr[ADDR_WIDTH-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign off      = req_addr[1:0];
    assign req_err  = (req_size == 2'b11)
                    || ((req_size == 2'b01) && off[0])
                    || ((req_size == 2'b10) && (off != 2'b00))
                    || (32'(word_idx) >= 32'(DEPTH));
    assign req_ready = alive_q && (out_q < OUT_W'(FIFO_DEPTH));
    assign acc       = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign rd_word   = mem_q[mem_idx];

    // Lane enables and lane-replicated store data for the addressed bytes.
    always_comb begin
        be    = 4'b0000;
        wlane = req_wdata;
        case (req_size)
            2'b00: begin
                be[off] = 1'b1;
                wlane   = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array write on the accept edge; erroring stores never touch the array.
    always_ff @(posedge clock) begin
        if (acc && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= wlane[b*8 +: 8];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s_vld_q, s_err_q, s_we_q, s_uns_q;
        logic [1:0]            s_size_q, s_off_q;
        logic [DATA_WIDTH-1:0] s_word_q;

        // Control side of the extra read stage; cleared so in-flight work is discarded on reset.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                s_vld_q  <= 1'b0;
                s_err_q  <= 1'b0;
                s_we_q   <= 1'b0;
                s_uns_q  <= 1'b0;
                s_size_q <= 2'b00;
                s_off_q  <= 2'b00;
            end else begin
                s_vld_q  <= acc;
                s_err_q  <= req_err;
                s_we_q   <= req_we;
                s_uns_q  <= req_unsigned;
                s_size_q <= req_size;
                s_off_q  <= off;
            end
        end

        // Raw word captured on the accept edge.
        always_ff @(posedge clock) begin
            if (acc) begin
                s_word_q <= rd_word;
            end
        end

        assign f_vld  = s_vld_q;
        assign f_err  = s_err_q;
        assign f_we   = s_we_q;
        assign f_uns  = s_uns_q;
        assign f_size = s_size_q;
        assign f_off  = s_off_q;
        assign f_word = s_word_q;
    end else begin : g_lat1
        assign f_vld  = acc;
        assign f_err  = req_err;
        assign f_we   = req_we;
        assign f_uns  = req_unsigned;
        assign f_size = req_size;
        assign f_off  = off;
        assign f_word = rd_word;
    end

    // Lane select and sign/zero extension in the final stage.
    always_comb begin
        f_half  = f_off[1] ? f_word[31:16] : f_word[15:0];
        f_byte  = f_word[7:0];
        ld_data = '0;
        case (f_off)
            2'b01:   f_byte = f_word[15:8];
            2'b10:   f_byte = f_word[23:16];
            2'b11:   f_byte = f_word[31:24];
            default: f_byte = f_word[7:0];
        endcase
        case (f_size)
            2'b00:   ld_data = f_uns ? {24'h0, f_byte} : {{24{f_byte[7]}}, f_byte};
            2'b01:   ld_data = f_uns ? {16'h0, f_half} : {{16{f_half[15]}}, f_half};
            2'b10:   ld_data = f_word;
            default: ld_data = '0;
        endcase
        if (f_err || f_we) begin
            ld_data = '0;
        end
    end

    data_mem_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_vld_i (f_vld),
        .push_dat_i ({f_err, ld_data}),
        .pop_rdy_i  (rsp_ready),
        .pop_vld_o  (fifo_vld),
        .pop_dat_o  (fifo_dat)
    );

    assign rsp_valid = fifo_vld;
    assign rsp_data  = fifo_vld ? fifo_dat[DATA_WIDTH-1:0] : '0;
    assign rsp_err   = fifo_vld && fifo_dat[DATA_WIDTH];

    // Next outstanding count: accept adds a credit, pop returns one.
    always_comb begin
        out_d = out_q;
        case ({acc, pop})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    // Credit counter and the one-cycle post-reset hold-off on req_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            alive_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: instance 0 is DEPTH=32/L=1, instance 1 is DEPTH=64/L=2.
// Each request is driven on a falling edge and accepted on the next rising edge.
// Outputs are sampled on falling edges.

module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [7:0]  req_addr     [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_data     [2];
    logic        rsp_err      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_dut_a (
        .clock(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(8), .READ_LATENCY(2)) u_dut_b (
        .clock(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request with rsp_ready held high; checks latency, data and error flag.
    task automatic op(input int d, input logic we, input logic [7:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input logic [31:0] exp_data,
                      input logic exp_err, input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_size[d] = size;
        req_unsigned[d] = uns; req_wdata[d] = wdata; rsp_ready[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk({tag, "_accept"}, 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[d] && n < 10);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_data"}, rsp_data[d], exp_data);
        chk({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        int stale;
        logic rdy;
        logic [31:0] exp_q [3];

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_size[d] = 2'b10; req_unsigned[d] = 1'b0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
        end
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_data", rsp_data[0], 32'd0);
        chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
        chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1 chk("ready_before_edge", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge_a", 32'(req_ready[0]), 32'd1);
        chk("ready_after_edge_b", 32'(req_ready[1]), 32'd1);

        // Basic word store/load, response the cycle after accept.
        op(0, 1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1, "sw_10");
        op(0, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1, "lw_10");

        // Sign and zero extension.
        op(0, 1'b1, 8'h20, 2'b10, 1'b0, 32'h80F07F12, 32'h0, 1'b0, 1, "sw_20");
        op(0, 1'b0, 8'h23, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 1, "lb_23");
        op(0, 1'b0, 8'h23, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 1, "lbu_23");
        op(0, 1'b0, 8'h22, 2'b01, 1'b0, 32'h0, 32'hFFFF80F0, 1'b0, 1, "lh_22");
        op(0, 1'b0, 8'h20, 2'b01, 1'b1, 32'h0, 32'h00007F12, 1'b0, 1, "lhu_20");
        op(0, 1'b0, 8'h20, 2'b00, 1'b0, 32'h0, 32'h00000012, 1'b0, 1, "lb_20");

        // Byte and half lane stores.
        op(0, 1'b1, 8'h30, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 1, "sw_30");
        op(0, 1'b1, 8'h31, 2'b00, 1'b0, 32'h000000AA, 32'h0, 1'b0, 1, "sb_31");
        op(0, 1'b0, 8'h30, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0, 1, "lw_30_sb");
        op(0, 1'b1, 8'h32, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 1'b0, 1, "sh_32");
        op(0, 1'b0, 8'h30, 2'b10, 1'b0, 32'h0, 32'hBEEFAA44, 1'b0, 1, "lw_30_sh");

        // Errors, and the range boundary for DEPTH=32.
        op(0, 1'b1, 8'h31, 2'b10, 1'b0, 32'h55555555, 32'h0, 1'b1, 1, "sw_31_err");
        op(0, 1'b0, 8'h30, 2'b10, 1'b0, 32'h0, 32'hBEEFAA44, 1'b0, 1, "lw_30_kept");
        op(0, 1'b0, 8'h31, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, "lw_31_err");
        op(0, 1'b0, 8'h33, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1, "lh_33_err");
        op(0, 1'b0, 8'h30, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1, "size3_err");
        op(0, 1'b0, 8'hFC, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, "lw_FC_err");
        op(0, 1'b0, 8'h80, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, "lw_80_err");
        op(0, 1'b1, 8'h7C, 2'b10, 1'b0, 32'h0BADF00D, 32'h0, 1'b0, 1, "sw_7C");
        op(0, 1'b0, 8'h7C, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 1, "lw_7C");

        // Store immediately followed by a load of the same word.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h44; req_size[0] = 2'b10;
        req_wdata[0] = 32'hCAFEF00D; rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 req_we[0] = 1'b0;
        @(negedge clk);
        chk("b2b_ack_valid", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_ack_data", rsp_data[0], 32'h0);
        chk("b2b_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_ld_valid", 32'(rsp_valid[0]), 32'd1);
        chk("b2b_ld_data", rsp_data[0], 32'hCAFEF00D);

        // L=2: preload four words, latency of two.
        op(1, 1'b1, 8'h00, 2'b10, 1'b0, 32'h11111111, 32'h0, 1'b0, 2, "b_sw0");
        op(1, 1'b1, 8'h04, 2'b10, 1'b0, 32'h22222222, 32'h0, 1'b0, 2, "b_sw1");
        op(1, 1'b1, 8'h08, 2'b10, 1'b0, 32'h33333333, 32'h0, 1'b0, 2, "b_sw2");
        op(1, 1'b1, 8'h0C, 2'b10, 1'b0, 32'h44444444, 32'h0, 1'b0, 2, "b_sw3");

        // Full backpressure: exactly three accepted.
        @(negedge clk);
        rsp_ready[1] = 1'b0; req_valid[1] = 1'b1; req_we[1] = 1'b0;
        req_size[1] = 2'b10; req_unsigned[1] = 1'b0; req_addr[1] = 8'h00;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            rdy = req_ready[1];
            @(posedge clk);
            #1;
            if (rdy) begin
                acc++;
                req_addr[1] = req_addr[1] + 8'd4;
            end
            @(negedge clk);
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_ready_low", 32'(req_ready[1]), 32'd0);
        chk("bp_head_valid", 32'(rsp_valid[1]), 32'd1);
        chk("bp_head_data", rsp_data[1], 32'h11111111);
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
        @(negedge clk);
        chk("bp_ready_back", 32'(req_ready[1]), 32'd1);
        chk("bp_next_data", rsp_data[1], 32'h22222222);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        exp_q[0] = 32'h22222222; exp_q[1] = 32'h33333333; exp_q[2] = 32'h44444444;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!rsp_valid[1] && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("bp_drain%0d", k), rsp_data[1], exp_q[k]);
        end
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;

        // Reset with two responses queued.
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 8'h04;
        @(posedge clk);
        #1 req_addr[1] = 8'h08;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_queued_valid", 32'(rsp_valid[1]), 32'd1);
        #2 rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("mid_rst_data", rsp_data[1], 32'h0);
        chk("mid_rst_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1; rsp_ready[1] = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) stale++;
        end
        chk("mid_no_stale", 32'(stale), 32'd0);
        op(1, 1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'h33333333, 1'b0, 2, "mid_lw_08");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, pipelined data memory for the CPU load/store path, replacing the fixed 8-bit, single-cycle data RAM. Supports RISC-V byte, half and word accesses with sign or zero extension, byte-lane writes, and misalignment and out-of-range detection. Requests and responses use valid/ready handshakes with configurable read latency. A credit-counted response FIFO ensures no response is ever dropped under backpressure.

Parameters:
DATA_WIDTH, 32, word width in bits; must be 32 (byte/half/word decode).
DEPTH, 64, number of words in the array.
ADDR_WIDTH, 8, byte-address width; word index = req_addr[ADDR_WIDTH-1:2].
READ_LATENCY, 1, cycles from request accept to response entering the FIFO; legal values 1 or 2.
FIFO_DEPTH, READ_LATENCY+1, response FIFO entries; derived, not overridden.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous reset, active low.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  ADDR_WIDTH  byte address.
req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal and flagged as an error.
req_unsigned  input  1  load zero-extends (lbu/lhu); ignored for stores and words.
req_wdata  input  DATA_WIDTH  store data, right-aligned.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer takes response.
rsp_data  output  DATA_WIDTH  extended load data; 0 for stores and errors.
rsp_err  output  1  misaligned access, illegal size or word index >= DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0.
  - Pipeline, FIFO pointers and outstanding counter are cleared.
  - Array contents are not reset.
  - Stores accepted before reset remain in the array; in-flight responses are discarded.
  - req_ready rises on the first clock edge after reset deasserts.
- Accept = req_valid & req_ready. At most one request is accepted per cycle.
- req_ready = (outstanding < FIFO_DEPTH). outstanding counts in-flight pipeline entries plus FIFO entries.
  - Accept without pop: outstanding +1.
  - Pop without accept: outstanding -1.
  - Accept and pop in the same cycle: outstanding unchanged.
- Error check happens at accept:
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - size 11 is an error.
  - word index >= DEPTH is an error.
  - An erroring request performs no array access; its response has rsp_err=1 and rsp_data=0.
- Store: the array is written on the accept edge, lane-masked.
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
  - word: all lanes.
  - Other lanes are unchanged. A store still produces a response (ack) with rsp_data=0 and rsp_err=0.
- Load: the word is read on the accept edge.
  - Lane selection uses addr[1:0]. Extension follows req_size and req_unsigned, applied in the final pipeline stage.
  - Stores and loads complete in order. A load accepted the cycle after a store to the same address returns the stored value.
- Latency: a response enters the FIFO READ_LATENCY edges after accept.
  - With an empty FIFO, rsp_valid asserts in the cycle after that edge (L=1: cycle after accept; L=2: two cycles after).
- FIFO behaviour:
  - Responses stay in issue order.
  - rsp_valid = FIFO non-empty. rsp_data and rsp_err are stable while rsp_valid & !rsp_ready.
  - Pop happens on rsp_valid & rsp_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by credit. A push into a full FIFO is an assertion failure.
- Full backpressure (rsp_ready=0): exactly FIFO_DEPTH requests are accepted, then req_ready=0 until a pop. req_ready returns to 1 in the cycle after the pop edge.

Test Plan:
1. Reset with L=1: after reset, store word 0xDEADBEEF to addr 0x10, then load word from 0x10 -> rsp_data=0xDEADBEEF, rsp_err=0; the load response appears the cycle after its accept.
2. Sign and zero extension: store word 0x80F07F12 to addr 0x20.
   - lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080.
   - lh 0x22 -> 0xFFFF80F0; lhu 0x20 -> 0x00007F12.
   - lb 0x20 -> 0x00000012.
3. Byte-lane store: word 0x11223344 at 0x30, then sb 0xAA to 0x31 -> lw 0x30 returns 0x1122AA44. Then sh 0xBEEF to 0x32 -> lw returns 0xBEEFAA44.
4. Errors: lw at 0x31, lh at 0x33, size=11, and addr 0xFC with DEPTH=32 -> each gives rsp_err=1 and rsp_data=0. A preceding sw to 0x31 leaves word 0x30 unchanged.
5. Backpressure with L=2 and rsp_ready=0: back-to-back loads -> exactly 3 accepted, then req_ready=0. Raise rsp_ready for one cycle -> one response popped, req_ready=1 the next cycle, and responses are in issue order.
6. Reset mid-operation: assert reset while 2 responses are queued -> rsp_valid=0 immediately. After release, an earlier-accepted store is still readable and no stale response appears.
